// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the memory-stage controller: FSM encoding,
// default access timeout and the word-alignment mask.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

  localparam int         TIMEOUT_DEF = 15;
  localparam logic [1:0] ALIGN_MASK  = 2'b11;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/ack bus between the MEM-stage controller (master)
// and Data_Memory (slave); request is held until a one-cycle ack.
interface mem_stage_ctrl_if #(
  parameter int AW = 32
);

  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [AW-1:0] mem_wdata_o;
  logic          mem_ack_i;
  logic [AW-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );

endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage access controller between EX/MEM and Data_Memory: stalls the pipe from start until ack/timeout.
// Latency: start cycle + >=1 REQ cycle + 1 DONE cycle; stall_o drops in DONE while EX/MEM still holds the access.
module mem_stage_ctrl
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int AW      = 32
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                MemRead_i,
  input  logic                MemWrite_i,
  input  logic [AW-1:0]       addr_i,
  input  logic [AW-1:0]       wdata_i,
  mem_stage_ctrl_if.master    dmem,
  output logic                stall_o,
  output logic [AW-1:0]       rdata_o,
  output logic                align_err_o,
  output logic                timeout_o
);

  mem_state_t    state_q, state_d;
  logic [7:0]    wait_q;
  logic          req_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] wdata_q;
  logic          access;
  logic          aligned;
  logic          start;
  logic          wait_hit;

  assign access   = MemRead_i | MemWrite_i;
  assign aligned  = (addr_i[1:0] & ALIGN_MASK) == 2'b00;
  assign start    = (state_q == ST_IDLE) && access && aligned;
  // This REQ cycle is the TIMEOUT-th one without ack; an ack in it still wins.
  assign wait_hit = (wait_q + 8'd1) == 8'(TIMEOUT);

  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_REQ;
          stall_o = 1'b1;
        end
      end
      ST_REQ: begin
        stall_o = 1'b1;
        if (dmem.mem_ack_i || wait_hit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Reset must release the pipeline at once even while a request is still presented.
    if (!rst_n_i) begin
      stall_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      wait_q      <= 8'd0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_o     <= '0;
      align_err_o <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      state_q     <= state_d;
      align_err_o <= (state_q == ST_IDLE) && access && !aligned;
      timeout_o   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          wait_q <= 8'd0;
          if (start) begin
            req_q   <= 1'b1;
            we_q    <= MemWrite_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
          end
        end
        ST_REQ: begin
          if (dmem.mem_ack_i) begin
            req_q <= 1'b0;
            if (!we_q) begin
              rdata_o <= dmem.mem_rdata_i;
            end
          end else if (wait_hit) begin
            req_q     <= 1'b0;
            timeout_o <= 1'b1;
            if (!we_q) begin
              rdata_o <= '0;
            end
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        default: wait_q <= 8'd0;
      endcase
    end
  end

  assign dmem.mem_req_o   = req_q;
  assign dmem.mem_we_o    = we_q;
  assign dmem.mem_addr_o  = addr_q;
  assign dmem.mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: transaction-level model drives per-cycle expectations,
// a negedge compare process checks them, plus literal pins on stall counts and load results.
module tb_mem_stage_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        align_err;
  logic        tmo;

  mem_stage_ctrl_if #(.AW(32)) dmem ();

  mem_stage_ctrl #(.TIMEOUT(TO), .AW(32)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .MemRead_i   (mem_read),
    .MemWrite_i  (mem_write),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .dmem        (dmem.master),
    .stall_o     (stall),
    .rdata_o     (rdata),
    .align_err_o (align_err),
    .timeout_o   (tmo)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          stall_cnt = 0;
  int          req_cnt = 0;
  bit          chk_en = 1'b0;
  logic        exp_stall, exp_req, exp_we, exp_align, exp_to;
  logic [31:0] exp_addr, exp_wdata;
  logic [31:0] m_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (stall) stall_cnt++;
        if (dmem.mem_req_o) req_cnt++;
      end
      if (chk_en) begin
        chk("stall", {31'd0, stall}, {31'd0, exp_stall});
        chk("mem_req", {31'd0, dmem.mem_req_o}, {31'd0, exp_req});
        chk("align_err", {31'd0, align_err}, {31'd0, exp_align});
        chk("timeout", {31'd0, tmo}, {31'd0, exp_to});
        chk("rdata", rdata, m_rdata);
        if (exp_req) begin
          chk("mem_we", {31'd0, dmem.mem_we_o}, {31'd0, exp_we});
          chk("mem_addr", dmem.mem_addr_o, exp_addr);
          if (exp_we) chk("mem_wdata", dmem.mem_wdata_o, exp_wdata);
        end
      end
    end
  endtask

  // One EX/MEM instruction: ack_at = REQ cycle (1-based) carrying the ack, 0 = never.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input int ack_at,
                            input logic [31:0] rd_val, input int lit_stalls);
    bit ok_align;
    bit hit;
    int n_req;
    int s0;
    int q0;
    ok_align = (a[1:0] == 2'b00) && (rd || wr);
    hit      = (ack_at >= 1) && (ack_at <= TO);
    n_req    = ok_align ? (hit ? ack_at : TO) : 0;
    s0 = stall_cnt;
    q0 = req_cnt;
    mem_read = rd; mem_write = wr; addr = a; wdata = d;
    dmem.mem_ack_i = 1'b0;
    exp_stall = ok_align; exp_req = 1'b0; exp_align = 1'b0; exp_to = 1'b0;
    step();
    if (!ok_align) begin
      mem_read = 1'b0; mem_write = 1'b0;
      exp_align = rd || wr;
      exp_stall = 1'b0;
      step();
      exp_align = 1'b0;
    end else begin
      for (int k = 1; k <= n_req; k++) begin
        exp_stall = 1'b1; exp_req = 1'b1;
        exp_we = wr; exp_addr = a; exp_wdata = d;
        dmem.mem_ack_i   = (k == ack_at);
        dmem.mem_rdata_i = (k == ack_at) ? rd_val : 32'h5A5A_5A5A;
        step();
      end
      // DONE: old instruction still presented, a stray ack must be ignored.
      if (!wr) m_rdata = hit ? rd_val : 32'h0;
      exp_stall = 1'b0; exp_req = 1'b0; exp_to = !hit;
      dmem.mem_ack_i   = 1'b1;
      dmem.mem_rdata_i = ~m_rdata;
      step();
      dmem.mem_ack_i = 1'b0;
      exp_to = 1'b0;
    end
    chk("stall_cycles", stall_cnt - s0, ok_align ? n_req + 1 : 0);
    chk("req_cycles", req_cnt - q0, n_req);
    chk("stall_cycles_lit", stall_cnt - s0, lit_stalls);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    fork
      compare_loop();
    join_none
    rst_n = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
    dmem.mem_ack_i = 1'b0; dmem.mem_rdata_i = '0;
    m_rdata = '0;
    exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_align = 1'b0; exp_to = 1'b0;
    exp_addr = '0; exp_wdata = '0;
    step(); step();
    chk("rst_req", {31'd0, dmem.mem_req_o}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_addr", dmem.mem_addr_o, 32'd0);
    chk("rst_flags", {29'd0, dmem.mem_we_o, align_err, tmo}, 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    step();

    // No memory op: passes with zero stall, stray ack ignored.
    addr = 32'h44; dmem.mem_ack_i = 1'b1; dmem.mem_rdata_i = 32'h0BAD_0BAD;
    step(); step();
    dmem.mem_ack_i = 1'b0;

    run_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 32'hDEAD_BEEF, 2);
    chk("load_ack1_rdata", rdata, 32'hDEAD_BEEF);
    run_access(1'b0, 1'b1, 32'h0000_0020, 32'h0000_1234, 4, 32'h0, 5);
    chk("store_rdata_hold", rdata, 32'hDEAD_BEEF);
    run_access(1'b1, 1'b0, 32'h0000_0013, 32'h0, 0, 32'h0, 0);
    run_access(1'b1, 1'b0, 32'h0000_0024, 32'h0, TO, 32'hCAFE_0004, 5);
    chk("ack_at_limit_rdata", rdata, 32'hCAFE_0004);
    run_access(1'b0, 1'b1, 32'h0000_0040, 32'h0000_0077, 0, 32'h0, 5);
    chk("wr_timeout_hold", rdata, 32'hCAFE_0004);
    run_access(1'b1, 1'b0, 32'h0000_0030, 32'h0, 0, 32'h0, 5);
    chk("rd_timeout_zero", rdata, 32'h0);
    run_access(1'b1, 1'b0, 32'h0000_0050, 32'h0, 1, 32'h1111_1111, 2);
    run_access(1'b1, 1'b0, 32'h0000_0054, 32'h0, 2, 32'h2222_2222, 3);
    chk("b2b_rdata", rdata, 32'h2222_2222);
    run_access(1'b1, 1'b1, 32'h0000_0022, 32'h9, 0, 32'h0, 0);
    run_access(1'b1, 1'b1, 32'h0000_0064, 32'h0000_ABCD, 2, 32'h0000_EEEE, 3);
    chk("write_wins_hold", rdata, 32'h2222_2222);

    // Reset in the middle of a request.
    mem_read = 1'b1; mem_write = 1'b0; addr = 32'h60;
    exp_stall = 1'b1; exp_req = 1'b0;
    step();
    exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h60;
    step(); step();
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midreq_rst_req", {31'd0, dmem.mem_req_o}, 32'd0);
    chk("midreq_rst_stall", {31'd0, stall}, 32'd0);
    chk("midreq_rst_rdata", rdata, 32'd0);
    m_rdata = '0;
    mem_read = 1'b0; addr = '0;
    step();
    rst_n = 1'b1;
    exp_stall = 1'b0; exp_req = 1'b0; exp_align = 1'b0; exp_to = 1'b0;
    chk_en = 1'b1;
    dmem.mem_ack_i = 1'b1; dmem.mem_rdata_i = 32'hFFFF_FFFF;
    step();
    dmem.mem_ack_i = 1'b0;
    for (int i = 0; i < TO + 2; i++) step();
    chk("post_rst_rdata", rdata, 32'h0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum REQ-state cycles without ack before abort (range 1..255).
REQ-002 SHALL have parameter AW, default 32: address/data width.
REQ-003 clk_i  in  1  single clock, all state on rising edge.
REQ-004 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-005 MemRead_i  in  1  EX/MEM load request.
REQ-006 MemWrite_i  in  1  EX/MEM store request.
REQ-007 addr_i  in  AW  byte address from ALU result.
REQ-008 wdata_i  in  AW  store data (RT data).
REQ-009 mem_req_o  out  1  data-memory request, held until ack.
REQ-010 mem_we_o  out  1  1=write, 0=read; valid while mem_req_o=1.
REQ-011 mem_addr_o  out  AW  latched address; valid while mem_req_o=1.
REQ-012 mem_wdata_o  out  AW  latched store data.
REQ-013 mem_ack_i  in  1  data-memory completion, one-cycle pulse.
REQ-014 mem_rdata_i  in  AW  read data, valid with mem_ack_i.
REQ-015 stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
REQ-016 rdata_o  out  AW  load result to MEM/WB MUX_Regdata input.
REQ-017 align_err_o  out  1  one-cycle pulse, misaligned access dropped.
REQ-018 timeout_o  out  1  one-cycle pulse, access aborted.

Function
REQ-019 SHALL implement FSM states IDLE, REQ, DONE.
REQ-020 In IDLE, an access SHALL start when (MemRead_i|MemWrite_i)=1 and addr_i[1:0]=00; MemWrite_i SHALL win when both asserted.
REQ-021 stall_o SHALL be combinational: 1 in IDLE on start condition and throughout REQ; 0 in DONE and otherwise.
REQ-022 On start, addr_i, wdata_i, write flag SHALL be latched; next state REQ.
REQ-023 In REQ, mem_req_o SHALL be 1 (registered) with latched addr/we/wdata; outputs stable until ack or timeout.
REQ-024 mem_ack_i=1 in REQ SHALL move to DONE; for reads rdata_o SHALL load mem_rdata_i on that edge; for writes rdata_o SHALL hold.
REQ-025 Minimum latency: start cycle + 1 REQ cycle; stall_o high exactly 2 cycles when ack arrives in first REQ cycle.
REQ-026 A wait counter (8 bit) SHALL count REQ cycles without ack; when it equals TIMEOUT, SHALL go to DONE, drop mem_req_o, set rdata_o=0 for reads, pulse timeout_o in DONE.
REQ-027 Ack on the same cycle the counter hits TIMEOUT SHALL count as success (no timeout).
REQ-028 DONE SHALL last exactly one cycle and go to IDLE unconditionally, never starting a new access (EX/MEM still holds the old instruction).
REQ-029 Misaligned start in IDLE SHALL issue no request, not stall, pulse align_err_o the same cycle (registered, visible next cycle), stay IDLE.
REQ-030 mem_ack_i outside REQ SHALL be ignored.
REQ-031 Instructions with MemRead_i=MemWrite_i=0 SHALL pass with zero stall; rdata_o holds.

Reset
REQ-032 rst_n_i low SHALL immediately force IDLE, counter 0, all outputs 0, latched registers 0.
REQ-033 Reset during REQ SHALL abandon the access with no retry and no error pulse.

Structure
REQ-034 State encoding, TIMEOUT default and alignment mask (2'b11) SHALL live in shared package cpu_pkg.
REQ-035 Single module; counter and FSM inline, no sub-module.
REQ-036 SHALL be instantiated between EX/MEM register and Data_Memory, replacing the direct Control/ALU wiring.

Verification
REQ-037 Load addr 0x0000_0010, ack in first REQ cycle, rdata 0xDEAD_BEEF -> stall_o 2 cycles, rdata_o=0xDEADBEEF in DONE.
REQ-038 Store addr 0x20 data 0x1234, ack after 3 wait cycles -> mem_we_o=1, addr/data stable 4 REQ cycles, stall_o 5 cycles.
REQ-039 Load addr 0x0000_0013 -> no mem_req_o, stall_o=0, align_err_o one pulse.
REQ-040 Load with TIMEOUT=4, no ack -> mem_req_o 4 cycles, timeout_o pulse, rdata_o=0; ack at cycle 4 -> success instead.
REQ-041 rst_n_i low mid-REQ -> mem_req_o, stall_o to 0 asynchronously; later stray ack ignored.
REQ-042 Back-to-back loads -> second access starts in IDLE after DONE, never in DONE.
